cpu_run_ctrl: RTL

- Execution controller for the pipeline CPU board top.
- Turns the board's switch and buttons into a one-cycle clock-enable (`cpu_en`) for the CPU core. Three modes: continuous run at a programmable cadence, single-step per button press, or halted on a CPU break request.
- Also rotates the 7-segment display source select and counts retired enables for debug.
- Runs on the board clock, replacing the free-running divided CPU clock.

---
 rtl/cpu_run_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller producing a one-cycle CPU clock enable.
// Also rotates the display source select and counts retired enables.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 99_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        disp_btn,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] step_count,
  output logic [1:0]  disp_sel
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RUN_DIV + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DIV_TOP = RW'(RUN_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  logic [2:0] raw;
  logic [2:0] meta;
  logic [2:0] sync;
  logic [2:0] level;
  logic [2:0] level_d;
  logic [2:0] rise;

  assign raw = {disp_btn, step_btn, run_sw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= '0;
      sync    <= '0;
      level_d <= '0;
    end else begin
      meta    <= raw;
      sync    <= meta;
      level_d <= level;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt      <= '0;
        level[i] <= 1'b0;
      end else if (sync[i] == level[i]) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt      <= '0;
        level[i] <= sync[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;

  state_t        st;
  logic [RW-1:0] div_cnt;

  // Leaving RUN always parks the divider at 0 for the next entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      div_cnt <= '0;
    end else begin
      div_cnt <= '0;
      unique case (st)
        IDLE: begin
          if (level[0])
            st <= RUN;
          else if (rise[1])
            st <= STEP;
        end
        STEP: st <= IDLE;
        RUN: begin
          if (halt_req)
            st <= HALTED;
          else if (!level[0])
            st <= IDLE;
          else if (div_cnt != DIV_TOP)
            div_cnt <= div_cnt + 1'b1;
        end
        HALTED: begin
          if (!level[0])
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state  = st;
  assign cpu_en = (st == STEP) |
                  ((st == RUN) & (div_cnt == DIV_TOP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      step_count <= '0;
    else if (cpu_en)
      step_count <= step_count + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      disp_sel <= '0;
    else if (rise[2])
      disp_sel <= disp_sel + 2'd1;
  end

endmodule
